// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg: shared FSM encoding and sizing helpers for the serial nibble receiver.
`default_nettype none

package serial_rx_pkg;

  localparam int DEFAULT_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Bit-index counter width; a 1-bit payload still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_nibble_rx_shift.sv
// rx_shift: payload register loaded one bit at a time at a given index, with clear.
`default_nettype none

module rx_shift #(
  parameter int DATA_W = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [IDX_W-1:0]  idx,
  input  logic              din,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data <= '0;
    end else if (en) begin
      data[idx] <= din;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_nibble_rx.sv
// serial_nibble_rx: start bit + LSB-first payload + parity bit receiver, gated by sin_en.
`default_nettype none

module serial_nibble_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter bit EVEN_PAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              sin_en,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              par_err,
  output logic              busy
);

  localparam int               CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   payload;
  logic                shift_clr;
  logic                shift_en;
  logic                par_ok;

  assign shift_clr = sin_en && (state == IDLE) && sin;
  assign shift_en  = sin_en && (state == DATA);
  // Combined XOR of payload and parity bit must be 0 for even, 1 for odd.
  assign par_ok    = ((^payload) ^ sin) != EVEN_PAR;

  rx_shift #(
    .DATA_W (DATA_W),
    .IDX_W  (CNT_W)
  ) u_shift (
    .clk  (clk),
    .rst  (rst),
    .clr  (shift_clr),
    .en   (shift_en),
    .idx  (cnt),
    .din  (sin),
    .data (payload)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      par_err <= 1'b0;
      busy    <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      par_err <= 1'b0;
      if (sin_en) begin
        case (state)
          IDLE: begin
            if (sin) begin
              state <= DATA;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          DATA: begin
            // Counter holds on the last bit; it only returns to 0 at the next start.
            if (cnt == LAST_IDX) begin
              state <= PARITY;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          PARITY: begin
            state <= IDLE;
            busy  <= 1'b0;
            if (par_ok) begin
              q       <= payload;
              q_valid <= 1'b1;
            end else begin
              par_err <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_nibble_rx.sv
// tb_serial_nibble_rx: table vectors, directed corner sequences and a randomized run vs a frame-level model.
`default_nettype none

module tb_serial_nibble_rx;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sin = 1'b0;
  logic          sin_en = 1'b0;
  logic [DW-1:0] q;
  logic          q_valid;
  logic          par_err;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Frame-level reference: collected bits since the start bit
  bit       m_active = 1'b0;
  bit       bq[$];
  int       m_q = 0;
  bit       m_valid = 1'b0;
  bit       m_err = 1'b0;

  serial_nibble_rx #(.DATA_W(DW), .EVEN_PAR(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .sin     (sin),
    .sin_en  (sin_en),
    .q       (q),
    .q_valid (q_valid),
    .par_err (par_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit en, input bit s);
    int payload;
    int ones;
    bit good;
    if (r) begin
      m_active = 1'b0;
      bq.delete();
      m_q = 0;
      m_valid = 1'b0;
      m_err = 1'b0;
      return;
    end
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!en) return;
    if (!m_active) begin
      if (s) begin
        m_active = 1'b1;
        bq.delete();
      end
    end else begin
      bq.push_back(s);
      if (bq.size() == DW + 1) begin
        payload = 0;
        for (int i = 0; i < DW; i++) payload += int'(bq[i]) << i;
        ones = $countones(payload) + int'(s);
        good = (ones % 2) == 0;
        if (good) begin
          m_q = payload;
          m_valid = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        m_active = 1'b0;
      end
    end
  endtask

  // One clock: apply inputs, let the edge pass, advance the model, compare all outputs.
  task automatic step(input bit r, input bit en, input bit s);
    rst = r; sin_en = en; sin = s;
    @(posedge clk);
    #1;
    cyc++;
    model_update(r, en, s);
    chk("model_q", int'(q), m_q);
    chk("model_q_valid", int'(q_valid), int'(m_valid));
    chk("model_par_err", int'(par_err), int'(m_err));
    chk("model_busy", int'(busy), int'(m_active));
  endtask

  // Sends start, DW data bits LSB first, parity; optional idle gap after data bit gap_at.
  task automatic send_frame(input logic [DW-1:0] d, input bit p, input int gap_at, input int gap_len);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < DW; i++) begin
      step(1'b0, 1'b1, d[i]);
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
          chk("gap_busy", int'(busy), 1);
        end
      end
    end
    step(1'b0, 1'b1, p);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    bit            par;
    bit            exp_valid;
    bit            exp_err;
    logic [DW-1:0] exp_q;
  } vec_t;

  vec_t vecs[6];
  int   t_first;
  int   n_valid;

  initial begin
    vecs[0] = '{4'h5, 1'b0, 1'b1, 1'b0, 4'h5};
    vecs[1] = '{4'h5, 1'b1, 1'b0, 1'b1, 4'h5};
    vecs[2] = '{4'h7, 1'b1, 1'b1, 1'b0, 4'h7};
    vecs[3] = '{4'h7, 1'b0, 1'b0, 1'b1, 4'h7};
    vecs[4] = '{4'h0, 1'b0, 1'b1, 1'b0, 4'h0};
    vecs[5] = '{4'h8, 1'b1, 1'b1, 1'b0, 4'h8};

    // Reset for two cycles
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("reset_q", int'(q), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pulses", int'(q_valid) + int'(par_err), 0);

    // Frame 1010, parity 0
    send_frame(4'b1010, 1'b0, -1, 0);
    chk("f1010_q", int'(q), 4'b1010);
    chk("f1010_valid", int'(q_valid), 1);
    step(1'b0, 1'b1, 1'b0);
    chk("f1010_valid_1cyc", int'(q_valid), 0);

    // 1100 with wrong parity
    send_frame(4'b1100, 1'b1, -1, 0);
    chk("bad_par_err", int'(par_err), 1);
    chk("bad_par_valid", int'(q_valid), 0);
    chk("bad_par_q_hold", int'(q), 4'b1010);
    step(1'b0, 1'b0, 1'b0);
    chk("bad_par_err_1cyc", int'(par_err), 0);

    // 1111 with a 3-cycle enable gap mid-data
    send_frame(4'b1111, 1'b0, 1, 3);
    chk("gap_q", int'(q), 4'b1111);
    chk("gap_valid", int'(q_valid), 1);
    step(1'b0, 1'b1, 1'b0);

    // Reset after two data bits of 0011, then a full 0011 frame
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("midrst_q", int'(q), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pulses", int'(q_valid) + int'(par_err), 0);
    send_frame(4'b0011, 1'b0, -1, 0);
    chk("after_rst_q", int'(q), 4'b0011);
    chk("after_rst_valid", int'(q_valid), 1);

    // Back-to-back 0001 (parity 1) then 0110 (parity 0)
    step(1'b0, 1'b1, 1'b0);
    send_frame(4'b0001, 1'b1, -1, 0);
    chk("b2b_q0", int'(q), 4'b0001);
    chk("b2b_valid0", int'(q_valid), 1);
    t_first = cyc;
    send_frame(4'b0110, 1'b0, -1, 0);
    chk("b2b_q1", int'(q), 4'b0110);
    chk("b2b_valid1", int'(q_valid), 1);
    chk("b2b_spacing", cyc - t_first, 6);

    // Idle line for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_pulses", int'(q_valid) + int'(par_err), 0);
    end

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].par, -1, 0);
      chk("tbl_valid", int'(q_valid), int'(vecs[i].exp_valid));
      chk("tbl_err", int'(par_err), int'(vecs[i].exp_err));
      chk("tbl_q", int'(q), int'(vecs[i].exp_q));
    end

    // Randomized traffic
    n_valid = 0;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      chk("excl_pulses", int'(q_valid && par_err), 0);
      if (q_valid) n_valid++;
    end
    n_tests++;
    if (n_valid == 0) begin
      n_fail++;
      $display("FAIL rand_activity: got %0d valid frames, expected more than 0", n_valid);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
